// File: rtl/clk_div_checker.sv
// clk_div_checker
//
// Receive-side checker for the clock-divider generator. The three divided
// clocks are sampled as plain data on every rising clk8f and packed into a
// 3-bit vector {clkf, clk2f, clk4f}. A correctly divided set of clocks
// makes that vector count up by one (mod 8) on every clk8f edge. A small
// FSM acquires lock on this count, reports any break while locked, and
// then goes back to acquiring lock.
//
// Optional feature (macro CLK_DIV_CHECKER_ERRCNT_EN):
//   Adds a saturating error counter output err_count [ERR_W-1:0].
//
// Parameters:
//   LOCK_CNT  consecutive correct transitions needed for lock (1..15)
//   ERR_W     width of err_count (used only with the optional feature)
//
// Ports:
//   clk8f      in   fastest clock, the only clock of the block
//   reset      in   asynchronous active-low reset
//   clkf_in    in   divided clock f (MSB of the sample vector)
//   clk2f_in   in   divided clock 2f
//   clk4f_in   in   divided clock 4f (LSB of the sample vector)
//   clr_err    in   synchronous clear of err_sticky (and err_count)
//   locked     out  high while the FSM is in LOCKED
//   err_pulse  out  one-cycle pulse per sequence break seen while locked
//   err_sticky out  set by an error, held until clr_err or reset
//   phase      out  last registered sample vector {clkf, clk2f, clk4f}
//   dbg_state  out  current FSM state (debug visibility)
//   err_count  out  saturating error count (optional feature only)

module clk_div_checker #(
   parameter int LOCK_CNT = 8,
   parameter int ERR_W    = 8
) (
   input  logic             clk8f,
   input  logic             reset,
   input  logic             clkf_in,
   input  logic             clk2f_in,
   input  logic             clk4f_in,
   input  logic             clr_err,
   output logic             locked,
   output logic             err_pulse,
   output logic             err_sticky,
   output logic [2:0]       phase,
   output logic [1:0]       dbg_state
`ifdef CLK_DIV_CHECKER_ERRCNT_EN
   ,
   output logic [ERR_W-1:0] err_count
`endif
);

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_LOCKED = 2'd1,
      ST_ERROR  = 2'd2
   } state_t;

   localparam logic [4:0] LOCK_TGT = 5'(LOCK_CNT);

   state_t     state;
   logic [3:0] match_cnt;
   logic [2:0] s_cur;
   logic [2:0] s_prev;
   logic       cur_valid;   // s_cur holds a real post-reset sample
   logic       prev_valid;  // s_prev also holds one: comparison allowed

   logic [2:0] s_in;
   logic       ok;
   logic       cmp_en;
   logic [4:0] cnt_inc;
   logic       err_set;

   assign s_in    = {clkf_in, clk2f_in, clk4f_in};
   // 3-bit addition wraps naturally, so 7 -> 0 counts as correct.
   assign ok      = (s_cur == (s_prev + 3'd1));
   assign cmp_en  = prev_valid;
   assign cnt_inc = {1'b0, match_cnt} + 5'd1;
   // A break seen while locked: ERROR is entered at the next edge.
   assign err_set = (state == ST_LOCKED) && cmp_en && !ok;

   assign phase     = s_cur;
   assign dbg_state = state;

   always_ff @(posedge clk8f or negedge reset) begin
      if (!reset) begin
         state      <= ST_SEARCH;
         match_cnt  <= 4'd0;
         s_cur      <= 3'd0;
         s_prev     <= 3'd0;
         cur_valid  <= 1'b0;
         prev_valid <= 1'b0;
         locked     <= 1'b0;
         err_pulse  <= 1'b0;
         err_sticky <= 1'b0;
      end else begin
         s_prev     <= s_cur;
         s_cur      <= s_in;
         cur_valid  <= 1'b1;
         prev_valid <= cur_valid;
         err_pulse  <= err_set;

         case (state)
            ST_SEARCH: begin
               if (cmp_en) begin
                  if (ok) begin
                     if (cnt_inc >= LOCK_TGT) begin
                        state     <= ST_LOCKED;
                        locked    <= 1'b1;
                        match_cnt <= 4'd0;
                     end else begin
                        match_cnt <= cnt_inc[3:0];
                     end
                  end else begin
                     match_cnt <= 4'd0;
                  end
               end
            end
            ST_LOCKED: begin
               if (err_set) begin
                  state  <= ST_ERROR;
                  locked <= 1'b0;
               end
            end
            ST_ERROR: begin
               // The comparison made during the error cycle already counts
               // as the first match of the new search.
               state     <= ST_SEARCH;
               match_cnt <= (cmp_en && ok) ? 4'd1 : 4'd0;
            end
            default: begin
               state     <= ST_SEARCH;
               locked    <= 1'b0;
               match_cnt <= 4'd0;
            end
         endcase

         // Setting wins over clearing, both on the edge that raises
         // err_pulse and on the edge that ends it.
         if (err_set || err_pulse) begin
            err_sticky <= 1'b1;
         end else if (clr_err) begin
            err_sticky <= 1'b0;
         end
      end
   end

`ifdef CLK_DIV_CHECKER_ERRCNT_EN
   localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

   // Counts on the same edge that raises err_pulse, saturating at all-ones.
   always_ff @(posedge clk8f or negedge reset) begin
      if (!reset) begin
         err_count <= '0;
      end else if (err_set) begin
         if (clr_err) begin
            err_count <= ERR_W'(1);
         end else if (err_count != ERR_MAX) begin
            err_count <= err_count + ERR_W'(1);
         end
      end else if (clr_err) begin
         err_count <= '0;
      end
   end
`endif

endmodule
